// File: rtl/led_scan_capture.sv
// Captures a multiplexed active-low 7-segment bus into a frame of 4-bit character codes with valid/ready output.
// Optional macro LED_SCAN_CHANGE_ONLY_EN: suppress completed frames identical to the last presented one.
module led_scan_capture #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic [6:0]              seg,
   output logic [4*NUM_DIGITS-1:0] chars,
   output logic [NUM_DIGITS-1:0]   bad_digit,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic                    overrun
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HELD   = 2'd2;

   // Returns {bad, code}; unknown patterns map to 4'hC with bad set.
   function automatic logic [4:0] encode_seg(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'b0000001: r = 5'h00;
         7'b1001111: r = 5'h01;
         7'b0010010: r = 5'h02;
         7'b0000110: r = 5'h03;
         7'b1001100: r = 5'h04;
         7'b0100100: r = 5'h05;
         7'b0100000: r = 5'h06;
         7'b0001111: r = 5'h07;
         7'b0000000: r = 5'h08;
         7'b0000100: r = 5'h09;
         7'b1111110: r = 5'h0A;
         7'b0111000: r = 5'h0F;
         7'b1111111: r = 5'h0B;
         default:    r = 5'h1C;
      endcase
      return r;
   endfunction

   logic [NUM_DIGITS-1:0]   an_s1_q, an_s1_d, an_s2_q, an_s2_d;
   logic [6:0]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
   logic [1:0]              state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [IDX_W-1:0]        ref_idx_q, ref_idx_d;
   logic [6:0]              ref_seg_q, ref_seg_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d, mask_set;
   logic [4*NUM_DIGITS-1:0] shadow_code_q, shadow_code_d;
   logic [NUM_DIGITS-1:0]   shadow_bad_q, shadow_bad_d;
   logic                    complete_q, complete_d;
   logic [4*NUM_DIGITS-1:0] chars_q, chars_d;
   logic [NUM_DIGITS-1:0]   bad_q, bad_d;
   logic                    fv_q, fv_d;
   logic                    ovr_q, ovr_d;
`ifdef LED_SCAN_CHANGE_ONLY_EN
   logic [4*NUM_DIGITS-1:0] last_code_q, last_code_d;
   logic [NUM_DIGITS-1:0]   last_bad_q, last_bad_d;
   logic                    have_last_q, have_last_d;
`endif

   logic             legal;
   logic [IDX_W-1:0] samp_idx;
   logic             match;
   logic             capture;
   logic             frame_dup;
   logic [4:0]       enc;

   // Legal sample: exactly one anode low.
   always_comb begin
      samp_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an_s2_q[i]) samp_idx = IDX_W'(i);
      end
      legal = ($countones(~an_s2_q) == 1);
      match = legal && (samp_idx == ref_idx_q) && (seg_s2_q == ref_seg_q);
      enc   = encode_seg(seg_s2_q);
   end

   always_comb begin
      an_s1_d   = an;
      an_s2_d   = an_s1_q;
      seg_s1_d  = seg;
      seg_s2_d  = seg_s1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      ref_idx_d = ref_idx_q;
      ref_seg_d = ref_seg_q;
      capture   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (legal) begin
               ref_idx_d = samp_idx;
               ref_seg_d = seg_s2_q;
               cnt_d     = 8'd1;
               state_d   = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!legal) begin
               state_d = ST_IDLE;
            end else if (match) begin
               if (cnt_q + 8'd1 == STABLE_CNT) begin
                  capture = 1'b1;
                  state_d = ST_HELD;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end else begin
               ref_idx_d = samp_idx;
               ref_seg_d = seg_s2_q;
               cnt_d     = 8'd1;
            end
         end
         ST_HELD: begin
            if (!legal) begin
               state_d = ST_IDLE;
            end else if (!match) begin
               ref_idx_d = samp_idx;
               ref_seg_d = seg_s2_q;
               cnt_d     = 8'd1;
               state_d   = ST_SETTLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shadow frame assembly; the capture that fills the mask also clears it.
   always_comb begin
      shadow_code_d = shadow_code_q;
      shadow_bad_d  = shadow_bad_q;
      mask_set      = mask_q;
      mask_d        = mask_q;
      complete_d    = 1'b0;
      if (capture) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ref_idx_q == IDX_W'(i)) begin
               shadow_code_d[4*i +: 4] = enc[3:0];
               shadow_bad_d[i]         = enc[4];
               mask_set[i]             = 1'b1;
            end
         end
         if (&mask_set) begin
            mask_d     = '0;
            complete_d = 1'b1;
         end else begin
            mask_d = mask_set;
         end
      end
   end

   always_comb begin
      chars_d   = chars_q;
      bad_d     = bad_q;
      fv_d      = fv_q;
      ovr_d     = ovr_q;
      frame_dup = 1'b0;
`ifdef LED_SCAN_CHANGE_ONLY_EN
      last_code_d = last_code_q;
      last_bad_d  = last_bad_q;
      have_last_d = have_last_q;
      frame_dup   = have_last_q && (shadow_code_q == last_code_q) && (shadow_bad_q == last_bad_q);
`endif
      if (fv_q && frame_ready) fv_d = 1'b0;
      if (complete_q && !frame_dup) begin
         if (!fv_q || frame_ready) begin
            chars_d = shadow_code_q;
            bad_d   = shadow_bad_q;
            fv_d    = 1'b1;
`ifdef LED_SCAN_CHANGE_ONLY_EN
            last_code_d = shadow_code_q;
            last_bad_d  = shadow_bad_q;
            have_last_d = 1'b1;
`endif
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_s1_q       <= '1;
         an_s2_q       <= '1;
         seg_s1_q      <= 7'b1111111;
         seg_s2_q      <= 7'b1111111;
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         ref_idx_q     <= '0;
         ref_seg_q     <= '0;
         mask_q        <= '0;
         shadow_code_q <= '0;
         shadow_bad_q  <= '0;
         complete_q    <= 1'b0;
         chars_q       <= '0;
         bad_q         <= '0;
         fv_q          <= 1'b0;
         ovr_q         <= 1'b0;
`ifdef LED_SCAN_CHANGE_ONLY_EN
         last_code_q   <= '0;
         last_bad_q    <= '0;
         have_last_q   <= 1'b0;
`endif
      end else begin
         an_s1_q       <= an_s1_d;
         an_s2_q       <= an_s2_d;
         seg_s1_q      <= seg_s1_d;
         seg_s2_q      <= seg_s2_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ref_idx_q     <= ref_idx_d;
         ref_seg_q     <= ref_seg_d;
         mask_q        <= mask_d;
         shadow_code_q <= shadow_code_d;
         shadow_bad_q  <= shadow_bad_d;
         complete_q    <= complete_d;
         chars_q       <= chars_d;
         bad_q         <= bad_d;
         fv_q          <= fv_d;
         ovr_q         <= ovr_d;
`ifdef LED_SCAN_CHANGE_ONLY_EN
         last_code_q   <= last_code_d;
         last_bad_q    <= last_bad_d;
         have_last_q   <= have_last_d;
`endif
      end
   end

   assign chars       = chars_q;
   assign bad_digit   = bad_q;
   assign frame_valid = fv_q;
   assign overrun     = ovr_q;

endmodule
